// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, beat type and FIFO state encoding
// for the FIR sample packer.
package fir_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int P_SAMPLES  = 8;
  localparam int CHANNELS   = 2;

  localparam int BEAT_W = CHANNELS * P_SAMPLES * DATA_WIDTH;
  localparam int LANE_W = $clog2(P_SAMPLES);

  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } fifo_state_e;

endpackage

// File: rtl/fir_sample_packer_if.sv
// fir_sample_packer_if: sample-pair input, flush/busy and the
// beat stream; master is the packer, slave its environment.
interface fir_sample_packer_if;
  import fir_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_ch0;
  logic [DATA_WIDTH-1:0] in_ch1;
  logic                  flush;
  logic                  m_tvalid;
  logic                  m_tready;
  beat_t                 m_tdata;
  logic                  busy;

  modport master (
    input  in_valid,
    input  in_ch0,
    input  in_ch1,
    input  flush,
    input  m_tready,
    output in_ready,
    output m_tvalid,
    output m_tdata,
    output busy
  );

  modport slave (
    output in_valid,
    output in_ch0,
    output in_ch1,
    output flush,
    output m_tready,
    input  in_ready,
    input  m_tvalid,
    input  m_tdata,
    input  busy
  );

endinterface

// File: rtl/fir_beat_fifo.sv
// fir_beat_fifo: 2-entry registered beat FIFO; the head register
// drives the stream outputs directly.
module fir_beat_fifo
  import fir_pkg::*;
(
  input  logic  clk,
  input  logic  nrst,
  input  logic  push_i,
  input  beat_t din_i,
  input  logic  ready_i,
  output logic  valid_o,
  output beat_t data_o,
  output logic  full_o,
  output logic  empty_o
);

  fifo_state_e state_q, state_d;
  beat_t       head_q, head_d;
  beat_t       tail_q, tail_d;
  logic        pop;

  assign pop = (state_q != EMPTY) && ready_i;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push_i) begin
          head_d  = din_i;
          state_d = ONE;
        end
      end
      ONE: begin
        unique case ({push_i, pop})
          2'b11: head_d = din_i;
          2'b10: begin
            tail_d  = din_i;
            state_d = TWO;
          end
          2'b01: state_d = EMPTY;
          default: ;
        endcase
      end
      TWO: begin
        // the packer never pushes here
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign valid_o = state_q != EMPTY;
  assign data_o  = head_q;
  assign full_o  = state_q == TWO;
  assign empty_o = state_q == EMPTY;

endmodule

// File: rtl/fir_sample_packer.sv
// fir_sample_packer: packs CH0/CH1 sample pairs into 256-bit beats
// for the FIR; FIR_PACKER_STATS_EN adds beat/stall counters.
module fir_sample_packer
  import fir_pkg::*;
(
  input  logic                clk,
  input  logic                nrst,
  fir_sample_packer_if.master bus
`ifdef FIR_PACKER_STATS_EN
  ,
  output logic [31:0]         beat_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  localparam logic [LANE_W-1:0] LAST = LANE_W'(P_SAMPLES - 1);

  logic                  armed_q;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] ch0_q [P_SAMPLES];
  logic [DATA_WIDTH-1:0] ch1_q [P_SAMPLES];

  logic  in_ready;
  logic  xfer;
  logic  last;
  logic  exec;
  logic  push;
  logic  full;
  logic  empty;
  beat_t push_beat;

  assign last = lane_q == LAST;

  // independent of m_tready: no combinational path in to out
  assign in_ready = armed_q && !pend_q && !(last && full);
  assign xfer     = bus.in_valid && in_ready;
  assign exec     = pend_q && !full;
  assign push     = (xfer && last) || exec;

  always_comb begin
    lane_d = lane_q;
    pend_d = pend_q;
    if (xfer) begin
      lane_d = last ? '0 : lane_q + LANE_W'(1);
    end
    if (exec) begin
      lane_d = '0;
      pend_d = 1'b0;
    end
    if (bus.flush && !pend_q && lane_d != '0) begin
      pend_d = 1'b1;
    end
  end

  always_comb begin
    push_beat = '0;
    for (int j = 0; j < P_SAMPLES; j++) begin
      logic [DATA_WIDTH-1:0] d0, d1;
      d0 = ch0_q[j];
      d1 = ch1_q[j];
      if (xfer && last && j == P_SAMPLES - 1) begin
        d0 = bus.in_ch0;
        d1 = bus.in_ch1;
      end else if (exec && j >= int'(lane_q)) begin
        d0 = '0;
        d1 = '0;
      end
      push_beat[DATA_WIDTH*j +: DATA_WIDTH] = d0;
      push_beat[P_SAMPLES*DATA_WIDTH + DATA_WIDTH*j +: DATA_WIDTH] = d1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      armed_q <= 1'b0;
      lane_q  <= '0;
      pend_q  <= 1'b0;
      for (int j = 0; j < P_SAMPLES; j++) begin
        ch0_q[j] <= '0;
        ch1_q[j] <= '0;
      end
    end else begin
      armed_q <= 1'b1;
      lane_q  <= lane_d;
      pend_q  <= pend_d;
      if (xfer) begin
        ch0_q[lane_q] <= bus.in_ch0;
        ch1_q[lane_q] <= bus.in_ch1;
      end
    end
  end

  fir_beat_fifo u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .push_i  (push),
    .din_i   (push_beat),
    .ready_i (bus.m_tready),
    .valid_o (bus.m_tvalid),
    .data_o  (bus.m_tdata),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.in_ready = in_ready;
  assign bus.busy     = (lane_q != '0) || pend_q || !empty;

`ifdef FIR_PACKER_STATS_EN
  logic [31:0] beat_q, stall_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      beat_q  <= '0;
      stall_q <= '0;
    end else begin
      if (push) beat_q <= beat_q + 32'd1;
      if (bus.in_valid && !in_ready) stall_q <= stall_q + 32'd1;
    end
  end

  assign beat_cnt  = beat_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fir_sample_packer.sv
// tb_fir_sample_packer: directed steps with a beat scoreboard
// for fir_sample_packer.
module tb_fir_sample_packer;
  import fir_pkg::*;

  logic clk;
  logic nrst;

  fir_sample_packer_if bus ();

`ifdef FIR_PACKER_STATS_EN
  logic [31:0] beat_cnt, stall_cnt;
`endif

  fir_sample_packer dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
`ifdef FIR_PACKER_STATS_EN
    ,
    .beat_cnt  (beat_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    vecs;
  int    errs;
  beat_t q [$];
  logic [15:0] m0 [8];
  logic [15:0] m1 [8];
  int    ml;

  task automatic chkb(input string tag, input beat_t obs, input beat_t exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic beat_t pack();
    beat_t b;
    b = '0;
    for (int j = 0; j < 8; j++) begin
      b[16*j +: 16]       = m0[j];
      b[128 + 16*j +: 16] = m1[j];
    end
    return b;
  endfunction

  task automatic acc(input logic [15:0] a, input logic [15:0] b);
    m0[ml] = a;
    m1[ml] = b;
    ml++;
    if (ml == 8) begin
      q.push_back(pack());
      ml = 0;
    end
  endtask

  task automatic acc_flush();
    if (ml != 0) begin
      for (int j = ml; j < 8; j++) begin
        m0[j] = '0;
        m1[j] = '0;
      end
      q.push_back(pack());
      ml = 0;
    end
  endtask

  task automatic nedge();
    @(negedge clk);
    if (bus.m_tvalid && bus.m_tready) begin
      chk1("pop_expected", q.size() > 0, 1'b1);
      if (q.size() > 0) chkb("pop_data", bus.m_tdata, q.pop_front());
    end
  endtask

  task automatic pedge();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int c = 0; c < budget && q.size() > 0; c++) begin
      nedge();
      pedge();
    end
    chkn(tag, q.size(), 0);
  endtask

  task automatic pair(input string tag, input logic [15:0] a,
                      input logic [15:0] b);
    bus.in_valid = 1'b1;
    bus.in_ch0   = a;
    bus.in_ch1   = b;
    nedge();
    chk1(tag, bus.in_ready, 1'b1);
    acc(a, b);
    pedge();
  endtask

  initial begin
    int n;
    vecs = 0;
    errs = 0;
    ml   = 0;
    nrst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_ch0   = '0;
    bus.in_ch1   = '0;
    bus.flush    = 1'b0;
    bus.m_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    chk1("rst_tvalid", bus.m_tvalid, 1'b0);
    chkb("rst_tdata", bus.m_tdata, '0);
    chk1("rst_busy", bus.busy, 1'b0);
    nrst = 1'b1;
    nedge();
    chk1("arm_wait", bus.in_ready, 1'b0);
    pedge();

    // continuous stream, ready held high
    bus.m_tready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.in_valid = 1'b1;
      bus.in_ch0   = 16'(k);
      bus.in_ch1   = 16'(16'h100 + k);
      nedge();
      chk1("t1_rdy", bus.in_ready, 1'b1);
      chk1("t1_tv", bus.m_tvalid, k == 8);
      acc(16'(k), 16'(16'h100 + k));
      pedge();
    end
    bus.in_valid = 1'b0;
    nedge();
    chk1("t1_tv_end", bus.m_tvalid, 1'b1);
    pedge();
    nedge();
    chk1("t1_idle", bus.m_tvalid, 1'b0);
    pedge();
    chkn("t1_q", q.size(), 0);

    // back-pressure: two beats fill the FIFO, third blocks at lane 7
    bus.m_tready = 1'b0;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      bus.in_valid = 1'b1;
      bus.in_ch0   = 16'(16'h200 + n);
      bus.in_ch1   = 16'(16'hA000 + n);
      nedge();
      chk1("t2_rdy", bus.in_ready, n < 23);
      if (n < 23) begin
        acc(16'(16'h200 + n), 16'(16'hA000 + n));
        n++;
      end
      pedge();
    end
`ifdef FIR_PACKER_STATS_EN
    chkn("t2_stall_cnt", int'(stall_cnt), 7);
    chkn("t2_beat_cnt", int'(beat_cnt), 4);
`endif
    chk1("t2_busy", bus.busy, 1'b1);
    bus.m_tready = 1'b1;
    nedge();
    chk1("t2_same_pop_blocked", bus.in_ready, 1'b0);
    pedge();
    nedge();
    chk1("t2_rdy_back", bus.in_ready, 1'b1);
    acc(16'(16'h200 + 23), 16'(16'hA000 + 23));
    pedge();
    bus.in_valid = 1'b0;
    drain("t2_drain", 10);

    // partial beat with flush, extreme signed values
    pair("t3_rdy", 16'h7FFF, 16'h0123);
    pair("t3_rdy", 16'h8000, 16'hFEDC);
    pair("t3_rdy", 16'h0001, 16'h8001);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    nedge();
    chk1("t3_busy", bus.busy, 1'b1);
    acc_flush();
    pedge();
    bus.flush = 1'b0;
    nedge();
    chk1("t3_pend_rdy", bus.in_ready, 1'b0);
    pedge();
    nedge();
    chk1("t3_tv", bus.m_tvalid, 1'b1);
    chkb("t3_pad", bus.m_tdata & {{128{1'b0}}, {80{1'b1}}, {48{1'b0}}}, '0);
    pedge();
    nedge();
    chk1("t3_busy_low", bus.busy, 1'b0);
    chk1("t3_tv_low", bus.m_tvalid, 1'b0);
    pedge();

    // flush while the FIFO is full, lane_cnt=2
    bus.m_tready = 1'b0;
    for (int k = 0; k < 18; k++) begin
      pair("t4_rdy", 16'(16'h300 + k), 16'(16'hC300 - k));
    end
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    nedge();
    acc_flush();
    pedge();
    bus.flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      nedge();
      chk1("t4_pend_rdy", bus.in_ready, 1'b0);
      chk1("t4_busy", bus.busy, 1'b1);
      pedge();
    end
    bus.m_tready = 1'b1;
    drain("t4_drain", 10);
    nedge();
    chk1("t4_rdy_back", bus.in_ready, 1'b1);
    chk1("t4_busy_low", bus.busy, 1'b0);
    pedge();

    // flush at lane 0, then flush on the completing transfer
    bus.flush = 1'b1;
    nedge();
    pedge();
    bus.flush = 1'b0;
    repeat (3) begin
      nedge();
      pedge();
    end
    chk1("t5_idle_tv", bus.m_tvalid, 1'b0);
    chk1("t5_idle_busy", bus.busy, 1'b0);
    for (int k = 0; k < 8; k++) begin
      bus.flush = (k == 7);
      pair("t5_rdy", 16'(16'h500 + k), 16'(16'h5A0 + k));
      if (k == 7) acc_flush();
    end
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    drain("t5_drain", 5);
    repeat (3) begin
      nedge();
      pedge();
    end
    chk1("t5_no_extra", bus.m_tvalid, 1'b0);
    chk1("t5_busy_low", bus.busy, 1'b0);

    // asynchronous reset mid-beat with one beat buffered
    bus.m_tready = 1'b0;
    for (int k = 0; k < 11; k++) begin
      pair("t6_rdy", 16'(16'h600 + k), 16'(16'h6F0 + k));
    end
    chk1("t6_pre_tv", bus.m_tvalid, 1'b1);
    nrst = 1'b0;
    #1;
    chk1("t6_rst_tv", bus.m_tvalid, 1'b0);
    chkb("t6_rst_tdata", bus.m_tdata, '0);
    chk1("t6_rst_rdy", bus.in_ready, 1'b0);
    chk1("t6_rst_busy", bus.busy, 1'b0);
    q.delete();
    ml = 0;
    bus.in_valid = 1'b0;
    pedge();
    nrst = 1'b1;
    nedge();
    chk1("t6_arm_wait", bus.in_ready, 1'b0);
    pedge();
    nedge();
    chk1("t6_armed", bus.in_ready, 1'b1);
    pedge();
    bus.m_tready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pair("t6_rdy2", 16'(16'h700 + k), 16'(16'h7F0 + k));
    end
    bus.in_valid = 1'b0;
    drain("t6_drain", 5);
`ifdef FIR_PACKER_STATS_EN
    chkn("t6_beat_cnt", int'(beat_cnt), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fir_sample_packer.md
# fir_sample_packer

- Stream source that feeds the dual-channel decimating FIR's input stream.
- Accepts one sample pair per handshake (CH0, CH1) and assembles P_SAMPLES consecutive pairs into one 256-bit beat.
- Buffers finished beats in a 2-entry output FIFO, so assembly continues while the FIR back-pressures.
- Presents beats on an AXI-Stream-style valid/ready master port, with lane ordering matching the FIR's delay-line load.

## Interface
- DATA_WIDTH, 16, sample width per channel
- P_SAMPLES, 8, parallel samples per channel per beat (power of two)
- CHANNELS, 2, channels per beat (fixed at 2)
- clk  in  1  single clock, all logic on rising edge
- nrst  in  1  reset, asynchronous, active-low
- in_valid  in  1  sample pair valid
- in_ready  out  1  packer can accept a pair this cycle
- in_ch0  in  DATA_WIDTH  CH0 sample, signed
- in_ch1  in  DATA_WIDTH  CH1 sample, signed
- flush  in  1  single-cycle request: emit the partial beat zero-padded
- m_tvalid  out  1  beat valid
- m_tready  in  1  downstream accepts the beat
- m_tdata  out  CHANNELS*P_SAMPLES*DATA_WIDTH  packed beat
- busy  out  1  partial beat, pending flush, or a non-empty FIFO exists

## Operation
- Lane map:
  - CH0 lane j at m_tdata[DATA_WIDTH*j +: DATA_WIDTH].
  - CH1 lane j at m_tdata[P_SAMPLES*DATA_WIDTH + DATA_WIDTH*j +: DATA_WIDTH].
  - Lane 0 holds the oldest sample of the beat, lane P_SAMPLES-1 the newest.
- Assembly register, with lane counter lane_cnt 0..P_SAMPLES-1:
  - A transfer (in_valid && in_ready) writes lane lane_cnt of both channels, then increments.
  - The transfer at lane P_SAMPLES-1 pushes the completed beat to the FIFO and wraps lane_cnt to 0.
- FIFO FSM: EMPTY -> ONE -> TWO on push; TWO -> ONE -> EMPTY on pop (m_tvalid && m_tready).
  - Push and pop in the same cycle keep the state.
  - A push in TWO never occurs; in_ready prevents it.
- armed flag: 0 in reset, set on the first clk edge after nrst deasserts.
- in_ready = armed && !flush_pend && !(lane_cnt==P_SAMPLES-1 && state==TWO).
  - in_ready does not depend on m_tready, so there is no combinational in-to-out path.
  - Consequence: a same-cycle pop does not unblock in_ready in state TWO.
- Flush:
  - A flush pulse sets flush_pend when lane_cnt>0 after any same-cycle transfer.
  - flush_pend executes on the first cycle with state!=TWO: lanes lane_cnt..P_SAMPLES-1 are zero-filled, the beat is pushed, lane_cnt goes to 0, and flush_pend clears.
- Flush corner cases:
  - Flush with lane_cnt==0, including when a same-cycle transfer just completed the beat: no-op.
  - Flush while flush_pend is already set: ignored.
- Samples pass through bit-exact; no arithmetic, rounding or sign change.

## Timing
- Reset values:
  - in_ready=0, m_tvalid=0, m_tdata=0, busy=0.
  - lane_cnt=0, state EMPTY, flush_pend=0, armed=0.
- Reset is asynchronous mid-operation: any partial beat and all FIFO contents are discarded with no output.
- m_tvalid and m_tdata are registered (FIFO head).
  - The beat is visible the cycle after the push edge.
  - Latency from the completing input edge to m_tvalid high is 1 cycle.
- Once asserted, m_tvalid stays high and m_tdata stays stable until the pop edge.
- With m_tready held high and continuous input, one beat is emitted every P_SAMPLES cycles and in_ready never drops.
- busy is registered and reflects state after each edge.

## Configuration
- FIR_PACKER_STATS_EN defined:
  - Adds outputs beat_cnt[31:0] (pushed beats, full and flushed) and stall_cnt[31:0] (cycles with in_valid && !in_ready).
  - Both are wrapping counters, reset 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

## Structure
- fir_pkg holds:
  - DATA_WIDTH, P_SAMPLES and CHANNELS defaults.
  - typedef beat_t (CHANNELS*P_SAMPLES*DATA_WIDTH bits).
  - FIFO state enum {EMPTY, ONE, TWO}.
- Sub-module fir_beat_fifo: 2-entry registered FIFO of beat_t, push/pop/full/empty, owns m_tvalid/m_tdata.

## Test plan
- Continuous input, m_tready=1, CH0=k, CH1=0x100+k for k=0..15 -> beats:
  - Beat 1: CH0 lanes 0..7 = 0..7, CH1 lanes = 0x100..0x107.
  - Beat 2: CH0 = 8..15.
  - m_tvalid high 1 cycle after k=7 and after k=15; in_ready always 1.
- m_tready=0, 24 pairs offered -> two beats held in the FIFO; in_ready drops at lane_cnt=7 with the third beat pending; stall count matches (STATS_EN).
  - Then m_tready=1 -> beats pop in order and in_ready returns.
- 3 pairs (0x7FFF, 0x8000, 0x0001), then flush -> CH0 lanes 0..2 = 0x7FFF, 0x8000, 0x0001; lanes 3..7 = 0; busy falls after the pop.
- Flush during FIFO TWO with lane_cnt=2 -> flush_pend holds and in_ready=0; after one pop, the padded beat is pushed.
- Flush with lane_cnt=0, and flush coincident with the lane-7 transfer -> no extra beat emitted.
- nrst asserted mid-beat with 1 beat in the FIFO -> all outputs 0 immediately; in_ready returns 1 cycle after release; next beat starts at lane 0.
